// File: rtl/serial_sub_nand_pkg.sv
// Shared definitions for the bit-serial NAND subtractor.
// Contents:
//   DEF_WIDTH : default operand width
//   DEF_CNT_W : default bit-counter width (2**DEF_CNT_W > DEF_WIDTH)
//   state_t   : sequencer state encoding; 2'd3 is unused and recovers to IDLE
package serial_sub_nand_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_nand_fs.sv
// fs_nand_only: structural one-bit full subtractor built only from nand gates.
// Ports:
//   x   in  1  minuend bit
//   y   in  1  subtrahend bit
//   bin in  1  borrow in
//   d   out 1  difference, x ^ y ^ bin
//   bo  out 1  borrow out, (~x & y) | (~(x ^ y) & bin)
module fs_nand_only (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic n1_s, n2_s, n3_s, t_s;
    logic m1_s, m2_s, m3_s;
    logic nx_s, tn_s, p_s, q_s;

    // t = x ^ y, classic four-nand XOR
    nand g_n1 (n1_s, x, y);
    nand g_n2 (n2_s, x, n1_s);
    nand g_n3 (n3_s, y, n1_s);
    nand g_t  (t_s, n2_s, n3_s);

    // d = t ^ bin, second four-nand XOR
    nand g_m1 (m1_s, t_s, bin);
    nand g_m2 (m2_s, t_s, m1_s);
    nand g_m3 (m3_s, bin, m1_s);
    nand g_d  (d, m2_s, m3_s);

    // Inverters as single-input nands
    nand g_nx (nx_s, x);
    nand g_tn (tn_s, t_s);

    // bo = ~(~(~x & y) & ~(~t & bin)) = (~x & y) | (~t & bin)
    nand g_p  (p_s, nx_s, y);
    nand g_q  (q_s, tn_s, bin);
    nand g_bo (bo, p_s, q_s);

endmodule

// File: rtl/serial_sub_nand.sv
// serial_sub_nand: bit-serial N-bit subtractor, diff = a - b mod 2**N, LSB first
// through a single NAND-only full-subtractor cell.
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high reset
//   start in  1  request, only looked at while idle
//   a     in  N  minuend, captured on accepted start
//   b     in  N  subtrahend, captured on accepted start
//   busy  out 1  high while running and during the done cycle
//   done  out 1  one-cycle pulse, diff/bout valid
//   diff  out N  result, partial while running
//   bout  out 1  final borrow, 1 iff a < b
import serial_sub_nand_pkg::*;

module serial_sub_nand #(
    parameter int N     = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] count_r;
    logic [N-1:0]     a_sh_r;
    logic [N-1:0]     b_sh_r;
    logic [N-1:0]     diff_r;
    logic             borrow_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             d_s;
    logic             bo_s;
    logic             last_s;
    logic             load_s;
    logic             shift_s;
    logic             fin_s;

    // The only datapath cell: one bit per cycle
    fs_nand_only u_fs (
        .x   (a_sh_r[0]),
        .y   (b_sh_r[0]),
        .bin (borrow_r),
        .d   (d_s),
        .bo  (bo_s)
    );

    assign last_s = (count_r == CNT_W'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = start ? RUN : IDLE;
            RUN:     state_nx_s = last_s ? DONE : RUN;
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Datapath control decode
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        fin_s   = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = start;
            end
            RUN: begin
                shift_s = 1'b1;
                fin_s   = last_s;
            end
            DONE: begin
                load_s = 1'b0;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Shift registers, counter, borrow and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            count_r  <= '0;
            bout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            // busy/done track the state being entered so they align with it
            busy_r <= (state_nx_s != IDLE);
            done_r <= (state_nx_s == DONE);
            if (load_s) begin
                a_sh_r   <= a;
                b_sh_r   <= b;
                diff_r   <= '0;
                borrow_r <= 1'b0;
                count_r  <= '0;
            end else if (shift_s) begin
                diff_r   <= {d_s, diff_r[N-1:1]};
                a_sh_r   <= a_sh_r >> 1;
                b_sh_r   <= b_sh_r >> 1;
                borrow_r <= bo_s;
                count_r  <= count_r + CNT_W'(1);
            end else begin
                count_r  <= count_r;
            end
            // Final borrow is the cell output of the last processed bit
            if (fin_s) begin
                bout_r <= bo_s;
            end else begin
                bout_r <= bout_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule
